// File: rtl/rotozoom_pkg.sv
// Shared widths, defaults and FSM encoding for the rotozoom per-frame parameter generator.
package rotozoom_pkg;

    localparam int unsigned TEX_FRAC_W    = 17;
    localparam int unsigned TABLE_W       = 16;
    localparam int unsigned ANGLE_W       = 9;
    localparam int unsigned PROD_W        = 32;
    localparam int unsigned DEFAULT_SHIFT = 21;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StMul,
        StCommit
    } state_e;

    // Floor-shift a product and keep the low texture-coordinate bits.
    function automatic logic [TEX_FRAC_W-1:0] scale_product(logic signed [PROD_W-1:0] p,
                                                           int unsigned shift);
        logic signed [PROD_W-1:0] s;
        s = p >>> shift;
        return s[TEX_FRAC_W-1:0];
    endfunction

endpackage

// File: rtl/seq_mul_s16.sv
// 16x16 signed sequential multiplier: one load cycle, 16 shift-add iterations on magnitudes,
// sign applied to the accumulated magnitude at the output.
module seq_mul_s16
    import rotozoom_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [TABLE_W-1:0] a,
    input  logic signed [TABLE_W-1:0] b,
    output logic                      done,
    output logic signed [PROD_W-1:0]  product
);

    logic               running_q;
    logic               done_q;
    logic               neg_q;
    logic [3:0]         iter_q;
    logic [PROD_W-1:0]  acc_q;
    logic [PROD_W-1:0]  mcand_q;
    logic [TABLE_W-1:0] mplier_q;
    logic [TABLE_W-1:0] mag_a;
    logic [TABLE_W-1:0] mag_b;

    // |-32768| is 32768, which still fits the unsigned 16-bit magnitude.
    always_comb begin
        mag_a = a[TABLE_W-1] ? TABLE_W'(-a) : TABLE_W'(a);
        mag_b = b[TABLE_W-1] ? TABLE_W'(-b) : TABLE_W'(b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            iter_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            done_q    <= 1'b0;
            neg_q     <= a[TABLE_W-1] ^ b[TABLE_W-1];
            iter_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= PROD_W'(mag_a);
            mplier_q  <= mag_b;
        end else begin
            done_q <= 1'b0;
            if (running_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                iter_q   <= iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = neg_q ? PROD_W'(-acc_q) : acc_q;

endmodule

// File: rtl/rotozoom_frame_params.sv
// Per-frame rotozoom parameter generator: advances the angle on frame start, computes strides
// and line-start offsets with one shared multiplier, and publishes all four atomically.
module rotozoom_frame_params
    import rotozoom_pkg::*;
#(
    parameter int unsigned CENTRE_X  = 320,
    parameter int unsigned CENTRE_Y  = 240,
    parameter int unsigned SHIFT     = DEFAULT_SHIFT,
    parameter int unsigned TABLE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [TABLE_W-1:0]    sin_val,
    input  logic [TABLE_W-1:0]    cos_val,
    input  logic [TABLE_W-1:0]    scale_val,
    output logic [ANGLE_W-1:0]    angle_idx,
    output logic [TEX_FRAC_W-1:0] u_stride,
    output logic [TEX_FRAC_W-1:0] v_stride,
    output logic [TEX_FRAC_W-1:0] u_start,
    output logic [TEX_FRAC_W-1:0] v_start,
    output logic                  params_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic signed [TABLE_W-1:0] CentreX = TABLE_W'(CENTRE_X);
    localparam logic signed [TABLE_W-1:0] CentreY = TABLE_W'(CENTRE_Y);

    state_e state_q, state_d;

    logic [ANGLE_W-1:0]    angle_q;
    logic                  overrun_q;
    logic [7:0]            lat_cnt_q;
    logic [1:0]            op_q;
    logic [1:0]            op_sel;
    logic                  first_q;
    logic signed [TABLE_W-1:0] sin_q, cos_q, scale_q;
    logic [TEX_FRAC_W-1:0] us_q, vs_q, uo_q;
    logic [TEX_FRAC_W-1:0] u_stride_q, v_stride_q, u_start_q, v_start_q;

    logic                      lookup_last;
    logic                      last_done;
    logic                      mul_start;
    logic                      mul_done;
    logic signed [TABLE_W-1:0] mul_a, mul_b;
    logic signed [PROD_W-1:0]  product;
    logic [TEX_FRAC_W-1:0]     product_scaled;

    assign lookup_last    = (state_q == StLookup) && (lat_cnt_q == 8'(TABLE_LAT));
    assign last_done      = (state_q == StMul) && mul_done && (op_q == 2'd3);
    assign product_scaled = scale_product(product, SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StLookup;
            StLookup: if (lookup_last) state_d = StMul;
            StMul:    if (last_done) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // The next operation is launched in the same cycle the previous one reports done.
    always_comb begin
        busy         = (state_q != StIdle);
        params_valid = (state_q == StCommit);
        mul_start    = (state_q == StMul) && (first_q || (mul_done && (op_q != 2'd3)));
        op_sel       = mul_done ? op_q + 2'd1 : op_q;
    end

    always_comb begin
        mul_a = scale_q;
        mul_b = cos_q;
        unique case (op_sel)
            2'd0: begin mul_a = scale_q; mul_b = cos_q; end
            2'd1: begin mul_a = scale_q; mul_b = sin_q; end
            2'd2: begin mul_a = CentreX; mul_b = cos_q; end
            2'd3: begin mul_a = CentreY; mul_b = sin_q; end
            default: ;
        endcase
    end

    seq_mul_s16 u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q    <= '0;
            overrun_q  <= 1'b0;
            lat_cnt_q  <= '0;
            op_q       <= '0;
            first_q    <= 1'b0;
            sin_q      <= '0;
            cos_q      <= '0;
            scale_q    <= '0;
            us_q       <= '0;
            vs_q       <= '0;
            uo_q       <= '0;
            u_stride_q <= '0;
            v_stride_q <= '0;
            u_start_q  <= '0;
            v_start_q  <= '0;
        end else begin
            first_q <= lookup_last;
            if (state_q == StIdle && frame_start) begin
                angle_q <= angle_q + 9'd1;
            end
            if (state_q != StIdle && frame_start) begin
                overrun_q <= 1'b1;
            end
            lat_cnt_q <= (state_q == StLookup) ? lat_cnt_q + 8'd1 : 8'd0;
            if (lookup_last) begin
                sin_q   <= sin_val;
                cos_q   <= cos_val;
                scale_q <= scale_val;
                op_q    <= '0;
            end
            if (state_q == StMul && mul_done) begin
                op_q <= op_q + 2'd1;
                case (op_q)
                    2'd0:    us_q <= product_scaled;
                    2'd1:    vs_q <= product_scaled;
                    2'd2:    uo_q <= product_scaled;
                    default: ;
                endcase
            end
            // All four outputs move on the same edge so a reader never sees a mixed set.
            if (last_done) begin
                u_stride_q <= us_q;
                v_stride_q <= vs_q;
                u_start_q  <= TEX_FRAC_W'(-uo_q);
                v_start_q  <= product_scaled;
            end
        end
    end

    assign angle_idx = angle_q;
    assign overrun   = overrun_q;
    assign u_stride  = u_stride_q;
    assign v_stride  = v_stride_q;
    assign u_start   = u_start_q;
    assign v_start   = v_start_q;

endmodule

// File: tb/tb_rotozoom_frame_params.sv
// Randomized scoreboard bench for rotozoom_frame_params with a table model and arithmetic reference.
module tb_rotozoom_frame_params;

    localparam int    CX  = 320;
    localparam int    CY  = 240;
    localparam int    SH  = 21;
    localparam longint LAT = 71;

    typedef struct {
        int     angle;
        int     us;
        int     vs;
        int     uo;
        int     vo;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic [15:0] sin_val, cos_val, scale_val;
    logic [8:0]  angle_idx;
    logic [16:0] u_stride, v_stride, u_start, v_start;
    logic params_valid, busy, overrun;

    logic signed [15:0] sin_tab [256];
    logic signed [15:0] cos_tab [256];
    logic signed [15:0] scale_tab [256];

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_pv = 0;
    int     angle_m = 0;
    longint cyc = 0;

    rotozoom_frame_params dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .sin_val      (sin_val),
        .cos_val      (cos_val),
        .scale_val    (scale_val),
        .angle_idx    (angle_idx),
        .u_stride     (u_stride),
        .v_stride     (v_stride),
        .u_start      (u_start),
        .v_start      (v_start),
        .params_valid (params_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External tables with one cycle of read latency.
    always @(posedge clk) begin
        sin_val   <= sin_tab[angle_idx[7:0]];
        cos_val   <= cos_tab[angle_idx[7:0]];
        scale_val <= scale_tab[angle_idx[8:1]];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic longint floor_shr(input longint p);
        longint d = longint'(1) << SH;
        longint q = p / d;
        if (p < 0 && q * d != p) q = q - 1;
        return q;
    endfunction

    function automatic int wrap17(input longint v);
        return int'(v & 64'h1FFFF);
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: return -32768;
            1: return 32767;
            2: return 0;
            default: return int'($signed(r));
        endcase
    endfunction

    // Monitor: pops one expectation per params_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && params_valid) begin
                n_pv++;
                if (sb.size() == 0) begin
                    check("unexpected_params_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("angle_idx", angle_idx, e.angle);
                    check("u_stride", u_stride, e.us);
                    check("v_stride", v_stride, e.vs);
                    check("u_start", u_start, e.uo);
                    check("v_start", v_start, e.vo);
                    check("latency", cyc, e.cyc);
                    check("busy_in_commit", busy, 1);
                end
            end
        end
    end

    // mode 0: plain frame; 1: second frame_start 10 cycles in; 2: frame_start during commit.
    task automatic run_frame(input int s, input int c, input int sn, input int mode);
        exp_t       e;
        logic [8:0] na;
        int         t;
        na = 9'(angle_m + 1);
        scale_tab[na[8:1]] = 16'(s);
        cos_tab[na[7:0]]   = 16'(c);
        sin_tab[na[7:0]]   = 16'(sn);
        e.angle = int'(na);
        e.us    = wrap17(floor_shr(longint'(s) * c));
        e.vs    = wrap17(floor_shr(longint'(s) * sn));
        e.uo    = wrap17(-floor_shr(longint'(CX) * c));
        e.vo    = wrap17(floor_shr(longint'(CY) * sn));
        e.cyc   = cyc + 1 + LAT;
        sb.push_back(e);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        angle_m = int'(na);
        if (mode == 1) begin
            repeat (9) @(posedge clk);
            #1 frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end else if (mode == 2) begin
            t = 0;
            while (!params_valid && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("frame_completed", sb.size(), 0);
            sb.delete();
        end
        check("busy_after_commit", busy, 0);
        check("angle_after_frame", angle_idx, angle_m);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            sin_tab[i] = '0;
            cos_tab[i] = '0;
            scale_tab[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_angle", angle_idx, 0);
        check("rst_u_stride", u_stride, 0);
        check("rst_u_start", u_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_params_valid", params_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort mid-multiply: nothing may be published afterwards.
        scale_tab[0] = 16'sd16384;
        cos_tab[1]   = 16'sd20000;
        sin_tab[1]   = -16'sd12000;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("midmul_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_angle", angle_idx, 0);
        check("abort_busy", busy, 0);
        check("abort_u_stride", u_stride, 0);
        check("abort_v_stride", v_stride, 0);
        check("abort_u_start", u_start, 0);
        check("abort_v_start", v_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_pulse", n_pv, 0);
        check("abort_idle", busy, 0);
        angle_m = 0;

        run_frame(16384, 32767, 0, 0);
        check("pos_u_stride", u_stride, 'h000FF);
        check("pos_u_start", u_start, 'h1FFFC);
        check("pos_angle", angle_idx, 1);
        run_frame(16384, -32768, 0, 0);
        check("neg_u_stride", u_stride, 'h1FF00);
        check("neg_u_start", u_start, 5);
        run_frame(-16384, 0, 16384, 0);
        check("sin_v_stride", v_stride, 'h1FF80);
        check("sin_v_start", v_start, 1);
        check("no_overrun_yet", overrun, 0);

        run_frame(rnd16(), rnd16(), rnd16(), 1);
        check("overrun_set", overrun, 1);
        check("overrun_pulses", n_pv, 4);
        run_frame(rnd16(), rnd16(), rnd16(), 2);
        repeat (80) @(posedge clk);
        #1;
        check("commit_start_ignored_angle", angle_idx, 5);
        check("commit_start_ignored_busy", busy, 0);

        for (int f = 5; f < 512; f++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame(rnd16(), rnd16(), rnd16(), 0);
        end
        check("wrap_angle", angle_idx, 0);
        check("pv_count", n_pv, 512);
        check("overrun_sticky", overrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
